// File: rtl/tiro_pkg.sv
// tiro_pkg: state encodings, opcode/mux constants and direction decode helpers for the shot datapath
package tiro_pkg;

    typedef enum logic [3:0] {
        INICIAL    = 4'd0,
        LIMPA      = 4'd1,
        ESPERA     = 4'd2,
        CARREGA    = 4'd3,
        VERIFICA   = 4'd4,
        MOVE       = 4'd6,
        COLISAO    = 4'd7,
        DESCARREGA = 4'd8,
        PROXIMO    = 4'd9,
        FIM        = 4'd10
    } estado_t;

    localparam logic [1:0] OP_CIMA    = 2'b00;
    localparam logic [1:0] OP_BAIXO   = 2'b01;
    localparam logic [1:0] OP_ESQ     = 2'b10;
    localparam logic [1:0] OP_DIR     = 2'b11;
    localparam logic [1:0] POS_ATUAL  = 2'b00;
    localparam logic [1:0] POS_MOVIDA = 2'b01;

    function automatic logic borda_dir(input logic [1:0] op, input logic x_min, input logic x_max,
                                       input logic y_min, input logic y_max);
        return op == OP_CIMA  ? y_min :
               op == OP_BAIXO ? y_max :
               op == OP_ESQ   ? x_min : x_max;
    endfunction

    // vertical moves operate on y, horizontal moves on x
    function automatic logic sel_coor(input logic [1:0] op);
        return ~op[1];
    endfunction

    // up and left decrement their coordinate
    function automatic logic sel_soma_sub(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/uc_atualiza_tiro.sv
// uc_atualiza_tiro: per-tick scan of all shot slots, moving each live shot and unloading
// those that hit an asteroid or leave the board.
module uc_atualiza_tiro
    import tiro_pkg::*;
#(
    parameter int WAIT_READ = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       atualiza_tiro,
    input  logic       loaded_tiro,
    input  logic       rco_contador_tiro,
    input  logic [1:0] opcode_tiro,
    input  logic       x_borda_min_tiro,
    input  logic       x_borda_max_tiro,
    input  logic       y_borda_min_tiro,
    input  logic       y_borda_max_tiro,
    input  logic       colisao_tiro_asteroide,
    output logic       clear_contador_tiro,
    output logic       conta_contador_tiro,
    output logic [1:0] select_mux_pos,
    output logic       select_mux_coor,
    output logic       select_soma_sub,
    output logic       enable_mem_tiro,
    output logic       enable_load_tiro,
    output logic       new_load,
    output logic       tiro_colidiu,
    output logic       tiro_atualizado,
    output logic [3:0] db_estado
);

    estado_t    estado_q;
    logic       colidiu_q;
    logic [1:0] espera_q;
    logic       calc;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q  <= INICIAL;
            colidiu_q <= 1'b0;
            espera_q  <= 2'd0;
        end else begin
            case (estado_q)
                INICIAL:  estado_q <= ESPERA;
                LIMPA:    estado_q <= CARREGA;
                ESPERA:   estado_q <= atualiza_tiro ? LIMPA : ESPERA;
                CARREGA: begin
                    if (espera_q == 2'(WAIT_READ - 1)) begin
                        espera_q <= 2'd0;
                        estado_q <= VERIFICA;
                    end else begin
                        espera_q <= espera_q + 2'd1;
                    end
                end
                VERIFICA: begin
                    if (!loaded_tiro) begin
                        estado_q <= PROXIMO;
                    end else if (colisao_tiro_asteroide) begin
                        colidiu_q <= 1'b1;
                        estado_q  <= DESCARREGA;
                    end else if (borda_dir(opcode_tiro, x_borda_min_tiro, x_borda_max_tiro,
                                           y_borda_min_tiro, y_borda_max_tiro)) begin
                        colidiu_q <= 1'b0;
                        estado_q  <= DESCARREGA;
                    end else begin
                        estado_q <= MOVE;
                    end
                end
                MOVE:     estado_q <= COLISAO;
                COLISAO: begin
                    if (colisao_tiro_asteroide) begin
                        colidiu_q <= 1'b1;
                        estado_q  <= DESCARREGA;
                    end else begin
                        estado_q <= PROXIMO;
                    end
                end
                DESCARREGA: begin
                    colidiu_q <= 1'b0;
                    estado_q  <= PROXIMO;
                end
                PROXIMO:  estado_q <= rco_contador_tiro ? FIM : CARREGA;
                FIM:      estado_q <= ESPERA;
                default: begin
                    colidiu_q <= 1'b0;
                    espera_q  <= 2'd0;
                    estado_q  <= INICIAL;
                end
            endcase
        end
    end

    // the moved coordinate stays visible on the datapath around the MOVE write
    assign calc                = estado_q inside {VERIFICA, MOVE, COLISAO};
    assign clear_contador_tiro = estado_q == LIMPA;
    assign conta_contador_tiro = estado_q == PROXIMO && !rco_contador_tiro;
    assign select_mux_pos      = estado_q == MOVE ? POS_MOVIDA : POS_ATUAL;
    assign select_mux_coor     = calc && sel_coor(opcode_tiro);
    assign select_soma_sub     = calc && sel_soma_sub(opcode_tiro);
    assign enable_mem_tiro     = estado_q == MOVE;
    assign enable_load_tiro    = estado_q == DESCARREGA;
    assign new_load            = 1'b0;
    assign tiro_colidiu        = estado_q == DESCARREGA && colidiu_q;
    assign tiro_atualizado     = estado_q == FIM;
    assign db_estado           = estado_q;

endmodule

// File: tb/tb_uc_atualiza_tiro.sv
// tb_uc_atualiza_tiro: drives the control unit against a model of shot memory and slot counter,
// comparing each whole scan with a slot-by-slot reference of the game rules.
module tb_uc_atualiza_tiro;

    localparam int W = 2;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       atualiza_tiro = 1'b0;
    logic       loaded_tiro, rco_contador_tiro, colisao_tiro_asteroide;
    logic       x_borda_min_tiro, x_borda_max_tiro, y_borda_min_tiro, y_borda_max_tiro;
    logic [1:0] opcode_tiro;
    logic       clear_contador_tiro, conta_contador_tiro, select_mux_coor, select_soma_sub;
    logic       enable_mem_tiro, enable_load_tiro, new_load, tiro_colidiu, tiro_atualizado;
    logic [1:0] select_mux_pos;
    logic [3:0] db_estado;

    logic [3:0]  slot = 4'd0;
    logic [15:0] ld = '0, mv = '0;
    logic [15:0] cfg_ld, cfg_cpre, cfg_cpost;
    logic [1:0]  cfg_op [16];
    logic [3:0]  cfg_bord [16];
    logic        load_cfg = 1'b0;
    int          n_chk = 0, n_fail = 0;

    uc_atualiza_tiro #(.WAIT_READ(W)) dut (
        .clock(clock), .reset(reset), .atualiza_tiro(atualiza_tiro), .loaded_tiro(loaded_tiro),
        .rco_contador_tiro(rco_contador_tiro), .opcode_tiro(opcode_tiro),
        .x_borda_min_tiro(x_borda_min_tiro), .x_borda_max_tiro(x_borda_max_tiro),
        .y_borda_min_tiro(y_borda_min_tiro), .y_borda_max_tiro(y_borda_max_tiro),
        .colisao_tiro_asteroide(colisao_tiro_asteroide),
        .clear_contador_tiro(clear_contador_tiro), .conta_contador_tiro(conta_contador_tiro),
        .select_mux_pos(select_mux_pos), .select_mux_coor(select_mux_coor),
        .select_soma_sub(select_soma_sub), .enable_mem_tiro(enable_mem_tiro),
        .enable_load_tiro(enable_load_tiro), .new_load(new_load), .tiro_colidiu(tiro_colidiu),
        .tiro_atualizado(tiro_atualizado), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    // datapath model: border vector is indexed by direction {right,left,down,up}
    assign loaded_tiro            = ld[slot];
    assign rco_contador_tiro      = slot == 4'd15;
    assign opcode_tiro            = cfg_op[slot];
    assign y_borda_min_tiro       = cfg_bord[slot][0];
    assign y_borda_max_tiro       = cfg_bord[slot][1];
    assign x_borda_min_tiro       = cfg_bord[slot][2];
    assign x_borda_max_tiro       = cfg_bord[slot][3];
    assign colisao_tiro_asteroide = mv[slot] ? cfg_cpost[slot] : cfg_cpre[slot];

    always @(posedge clock) begin
        if (load_cfg) begin
            ld <= cfg_ld;
            mv <= '0;
        end else begin
            if (enable_mem_tiro) mv[slot] <= 1'b1;
            if (enable_load_tiro) ld[slot] <= new_load;
        end
        if (clear_contador_tiro) slot <= 4'd0;
        else if (conta_contador_tiro) slot <= slot + 4'd1;
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic clear_cfg();
        cfg_ld = '0; cfg_cpre = '0; cfg_cpost = '0;
        for (int i = 0; i < 16; i++) begin
            cfg_op[i] = 2'd0;
            cfg_bord[i] = 4'd0;
        end
    endtask

    task automatic apply_cfg();
        @(negedge clock);
        load_cfg = 1'b1;
        @(negedge clock);
        load_cfg = 1'b0;
    endtask

    // expected {coor, soma_sub}: vertical moves use y, up/left subtract
    function automatic logic [1:0] exp_sel(input logic [1:0] op);
        case (op)
            2'd0: return 2'b11;
            2'd1: return 2'b10;
            2'd2: return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    function automatic void model(output int cyc, output int mvs, output int unl, output int hits,
                                  output logic [15:0] ld_after);
        cyc = 2; mvs = 0; unl = 0; hits = 0; ld_after = cfg_ld;
        for (int s = 0; s < 16; s++) begin
            if (!cfg_ld[s]) cyc += W + 2;
            else if (cfg_cpre[s]) begin
                cyc += W + 3; unl++; hits++; ld_after[s] = 1'b0;
            end else if (cfg_bord[s][cfg_op[s]]) begin
                cyc += W + 3; unl++; ld_after[s] = 1'b0;
            end else begin
                mvs++;
                if (cfg_cpost[s]) begin
                    cyc += W + 5; unl++; hits++; ld_after[s] = 1'b0;
                end else cyc += W + 4;
            end
        end
    endfunction

    task automatic run_scan(input bit hold, output int cyc, output int clr, output int cnt,
                            output int mvs, output int unl, output int hits, output int bad,
                            output bit done);
        cyc = 0; clr = 0; cnt = 0; mvs = 0; unl = 0; hits = 0; bad = 0; done = 0;
        @(negedge clock);
        atualiza_tiro = 1'b1;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge clock);
            cyc++;
            if (!hold) atualiza_tiro = 1'b0;
            if (clear_contador_tiro) clr++;
            if (conta_contador_tiro) cnt++;
            if (enable_mem_tiro) begin
                mvs++;
                if (select_mux_pos != 2'b01 || {select_mux_coor, select_soma_sub} != exp_sel(opcode_tiro))
                    bad++;
            end else if (select_mux_pos != 2'b00) bad++;
            if (enable_load_tiro) begin
                unl++;
                if (new_load) bad++;
            end
            if (tiro_colidiu) hits++;
            if (tiro_atualizado) done = 1;
        end
    endtask

    task automatic check_scan(input string nm);
        int ecyc, emv, eul, ehit, cyc, clr, cnt, mvs, unl, hits, bad;
        logic [15:0] eld;
        bit done;
        model(ecyc, emv, eul, ehit, eld);
        apply_cfg();
        run_scan(1'b0, cyc, clr, cnt, mvs, unl, hits, bad, done);
        chk({nm, " done"}, int'(done), 1);
        chk({nm, " cycles"}, cyc, ecyc);
        chk({nm, " clears"}, clr, 1);
        chk({nm, " contas"}, cnt, 15);
        chk({nm, " moves"}, mvs, emv);
        chk({nm, " unloads"}, unl, eul);
        chk({nm, " hits"}, hits, ehit);
        chk({nm, " select errors"}, bad, 0);
        chk({nm, " loaded flags"}, int'(ld), int'(eld));
    endtask

    typedef struct {
        int         s;
        bit         l;
        logic [1:0] op;
        logic [3:0] bord;
        bit         cpre, cpost;
        int         extra, mvs, unl, hits;
    } vec_t;

    vec_t tbl [9];

    initial begin
        int cyc, clr, cnt, mvs, unl, hits, bad, k;
        bit done;
        tbl[0] = '{3,  0, 2'd3, 4'hF, 1, 1, 0, 0, 0, 0};
        tbl[1] = '{3,  1, 2'd3, 4'h0, 0, 0, 2, 1, 0, 0};
        tbl[2] = '{0,  1, 2'd0, 4'h1, 0, 0, 1, 0, 1, 0};
        tbl[3] = '{5,  1, 2'd1, 4'h1, 0, 0, 2, 1, 0, 0};
        tbl[4] = '{7,  1, 2'd2, 4'h4, 0, 0, 1, 0, 1, 0};
        tbl[5] = '{0,  1, 2'd3, 4'h8, 0, 0, 1, 0, 1, 0};
        tbl[6] = '{5,  1, 2'd1, 4'h0, 0, 1, 3, 1, 1, 1};
        tbl[7] = '{5,  1, 2'd0, 4'h1, 1, 0, 1, 0, 1, 1};
        tbl[8] = '{15, 1, 2'd2, 4'hB, 0, 0, 2, 1, 0, 0};
        clear_cfg();
        repeat (3) @(negedge clock);
        chk("reset state", int'(db_estado), 0);
        chk("reset outputs", int'({clear_contador_tiro, conta_contador_tiro, select_mux_pos,
            select_mux_coor, select_soma_sub, enable_mem_tiro, enable_load_tiro, new_load,
            tiro_colidiu, tiro_atualizado}), 0);
        reset = 1'b1;
        @(negedge clock);
        chk("espera after reset", int'(db_estado), 2);

        clear_cfg();
        check_scan("empty");

        foreach (tbl[i]) begin
            clear_cfg();
            cfg_ld[tbl[i].s] = tbl[i].l;
            cfg_op[tbl[i].s] = tbl[i].op;
            cfg_bord[tbl[i].s] = tbl[i].bord;
            cfg_cpre[tbl[i].s] = tbl[i].cpre;
            cfg_cpost[tbl[i].s] = tbl[i].cpost;
            apply_cfg();
            run_scan(1'b0, cyc, clr, cnt, mvs, unl, hits, bad, done);
            chk($sformatf("vec%0d done", i), int'(done), 1);
            chk($sformatf("vec%0d cycles", i), cyc, 2 + 16 * (W + 2) + tbl[i].extra);
            chk($sformatf("vec%0d moves", i), mvs, tbl[i].mvs);
            chk($sformatf("vec%0d unloads", i), unl, tbl[i].unl);
            chk($sformatf("vec%0d hits", i), hits, tbl[i].hits);
            chk($sformatf("vec%0d selects", i), bad, 0);
            chk($sformatf("vec%0d loaded", i), int'(ld[tbl[i].s]), int'(tbl[i].l && tbl[i].unl == 0));
        end

        for (int r = 0; r < 8; r++) begin
            cfg_ld = 16'($urandom);
            for (int i = 0; i < 16; i++) begin
                cfg_op[i] = 2'($urandom);
                cfg_bord[i] = $urandom_range(0, 2) == 0 ? 4'($urandom) : 4'd0;
                cfg_cpre[i] = $urandom_range(0, 4) == 0;
                cfg_cpost[i] = $urandom_range(0, 3) == 0;
            end
            check_scan($sformatf("rand%0d", r));
        end

        clear_cfg();
        cfg_ld[0] = 1'b1;
        cfg_op[0] = 2'd3;
        apply_cfg();
        @(negedge clock);
        atualiza_tiro = 1'b1;
        k = 0;
        for (int i = 0; i < 50 && db_estado != 4'd6; i++) begin
            @(negedge clock);
            atualiza_tiro = 1'b0;
            k++;
        end
        chk("reached MOVE", int'(db_estado), 6);
        reset = 1'b0;
        #1;
        chk("async reset state", int'(db_estado), 0);
        chk("async reset outputs", int'({clear_contador_tiro, conta_contador_tiro, select_mux_pos,
            select_mux_coor, select_soma_sub, enable_mem_tiro, enable_load_tiro, new_load,
            tiro_colidiu, tiro_atualizado}), 0);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("espera after abort", int'(db_estado), 2);
        check_scan("rescan after abort");

        clear_cfg();
        apply_cfg();
        run_scan(1'b1, cyc, clr, cnt, mvs, unl, hits, bad, done);
        chk("held done", int'(done), 1);
        chk("held clears", clr, 1);
        chk("held cycles", cyc, 2 + 16 * (W + 2));
        @(negedge clock);
        chk("held back in espera", int'(db_estado), 2);
        @(negedge clock);
        chk("held second scan", int'(clear_contador_tiro), 1);
        atualiza_tiro = 1'b0;
        clr = 0; done = 0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clock);
            if (clear_contador_tiro) clr++;
            if (tiro_atualizado) done = 1;
        end
        chk("second scan done", int'(done), 1);
        chk("second scan no restart", clr, 0);
        repeat (3) @(negedge clock);
        chk("no queued scan", int'(db_estado), 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/uc_atualiza_tiro.md
Name: uc_atualiza_tiro

Overview:
- Control unit that sequences the shot datapath (`tiro`) once per game tick.
- On each `atualiza_tiro` request it scans every shot slot in shot memory. Per loaded slot, in order:
  - checks collision at the current position;
  - checks whether the shot sits at the board border for its direction;
  - moves the shot one cell along its opcode direction;
  - re-checks collision at the new position.
- A shot that collides or leaves the board is unloaded. The block sits beside `uc_registra_tiro` and drives the same datapath control pins; the game-level FSM guarantees the two are never active together.

Parameters:
- WAIT_READ, 1, memory read latency in cycles; the CARREGA state lasts WAIT_READ cycles before flags are sampled (legal 1..3).

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- atualiza_tiro  input  1  request to scan all shots; sampled only in ESPERA
- loaded_tiro  input  1  current slot holds an active shot
- rco_contador_tiro  input  1  slot counter is at its last slot
- opcode_tiro  input  2  direction of the current shot: 00 up (y-1), 01 down (y+1), 10 left (x-1), 11 right (x+1)
- x_borda_min_tiro, x_borda_max_tiro, y_borda_min_tiro, y_borda_max_tiro  input  1 each  current shot coordinate is at that border
- colisao_tiro_asteroide  input  1  current shot position matches a live asteroid
- clear_contador_tiro  output  1  synchronous clear of the slot counter
- conta_contador_tiro  output  1  increment the slot counter
- select_mux_pos  output  2  00 = stored position, 01 = moved position
- select_mux_coor  output  1  0 = x, 1 = y operand to the adder/subtractor
- select_soma_sub  output  1  0 = add, 1 = subtract
- enable_mem_tiro  output  1  write position to shot memory
- enable_load_tiro  output  1  write the loaded flag
- new_load  output  1  value written to the loaded flag (always 0 in this block)
- tiro_colidiu  output  1  one-cycle pulse for each shot destroyed by collision
- tiro_atualizado  output  1  one-cycle pulse when the scan completes
- db_estado  output  4  state encoding

Behaviour:
- Reset (reset=0, async): state INICIAL; every output 0; db_estado 0.
- Moore FSM; outputs decode from the registered state. Encodings:
  - INICIAL 0: go to ESPERA.
  - LIMPA 1: clear_contador_tiro=1; go to CARREGA.
  - ESPERA 2: if atualiza_tiro=1 go to LIMPA, else stay.
  - CARREGA 3: hold for WAIT_READ cycles (internal wait counter), then go to VERIFICA.
  - VERIFICA 4: choose the next state, first match wins:
    - loaded_tiro=0: go to PROXIMO.
    - colisao_tiro_asteroide=1: go to DESCARREGA with the colidiu flag set.
    - border flag for the shot's direction is 1 (up: y_min, down: y_max, left: x_min, right: x_max): go to DESCARREGA with the colidiu flag clear.
    - otherwise: go to MOVE.
  - MOVE 6:
    - select_mux_pos=01; enable_mem_tiro=1.
    - select_mux_coor = opcode[1]==0 ? 1 : 0.
    - select_soma_sub = 1 for opcode 00 or 10, else 0.
    - Go to COLISAO.
  - COLISAO 7: if colisao_tiro_asteroide=1, go to DESCARREGA with the colidiu flag set; else go to PROXIMO.
  - DESCARREGA 8:
    - enable_load_tiro=1; new_load=0.
    - tiro_colidiu=1 if the colidiu flag is set; the flag is cleared on exit.
    - Go to PROXIMO.
  - PROXIMO 9: if rco_contador_tiro=1 go to FIM; else conta_contador_tiro=1 and go to CARREGA.
  - FIM 10: tiro_atualizado=1 for exactly one cycle; go to ESPERA.
- select_mux_coor and select_soma_sub are also driven in VERIFICA and COLISAO from opcode_tiro, so the datapath shows the moved coordinate during those states. select_mux_pos is 00 in every state except MOVE.
- The colidiu flag is a single register set on the transitions into DESCARREGA named above.
- atualiza_tiro while not in ESPERA is ignored and not queued.
- Encodings 5 and 11..15 are unreachable; if entered, go to INICIAL.
- reset asserted mid-scan aborts immediately. Memory contents stay as partially updated, and the next request rescans from slot 0.
- The counter wraps naturally; this block never relies on wrap, because it exits on rco.
- Scan latency per slot, with W = WAIT_READ:
  - empty slot: W+2 cycles;
  - moved, no hit: W+4 cycles;
  - unloaded: W+3 or W+5 cycles.

Decomposition:
- Shared package `tiro_pkg`:
  - state encodings, shared with the db_estado display decoder;
  - opcode constants OP_CIMA=00, OP_BAIXO=01, OP_ESQ=10, OP_DIR=11;
  - select_mux_pos constants POS_ATUAL=00, POS_MOVIDA=01.
- No sub-module. The border select and the direction to coor/soma_sub decode are small combinational functions kept in the package.

Test Plan:
- Reset low mid-scan (state MOVE) -> db_estado=0 and all outputs 0 asynchronously; after release, ESPERA is reached in 1 cycle.
- All 16 slots empty, atualiza_tiro pulse -> 1 clear, 15 conta pulses, no enable_mem_tiro or enable_load_tiro, tiro_atualizado once after 16·(W+2)+2 cycles.
- Slot 3 loaded, opcode 11, no border, no hit -> in slot 3 exactly one MOVE with select_mux_pos=01, select_mux_coor=0, select_soma_sub=0, enable_mem_tiro=1; no unload.
- Slot 0 loaded, opcode 00, y_borda_min_tiro=1 and collision=0 -> DESCARREGA with new_load=0; tiro_colidiu stays 0; no MOVE.
- Slot 5 loaded, collision raised only after the move -> MOVE, then COLISAO, then DESCARREGA; tiro_colidiu pulses for 1 cycle. With collision and border both 1 in VERIFICA -> DESCARREGA with tiro_colidiu=1, collision taking priority.
- atualiza_tiro held high through the whole scan -> exactly one scan, then a second scan starts immediately from ESPERA; the extra requests are not queued.
